iter_divider: RTL and testbench

//  Iterative radix-2 restoring divider for MIPS DIV/DIVU in the E stage.
//  - Feeds the hazard unit: div_stall drives div_stallE, which freezes F..W while a divide runs.
//  - Produces {HI,LO} = {remainder, quotient} for the HI/LO write in later stages.

---
 rtl/iter_divider.sv | 191 +++++++++++++++++++
 tb/tb_iter_divider.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// -----------------------------------------------------------------------------
// iter_divider
//   Iterative radix-2 restoring divider for MIPS DIV/DIVU in the E stage.
//   One quotient bit is produced per clock, so a divide occupies the E stage
//   for WIDTH+1 stall cycles (entry cycle + WIDTH iterations) before the
//   result is presented in DONE.
//
// Ports
//   clk         in   1        clock, rising edge
//   rst         in   1        asynchronous, active-low reset
//   div_en      in   1        DIV/DIVU instruction valid in E stage
//   div_signed  in   1        1 = DIV (signed), 0 = DIVU
//   src_a       in   WIDTH    dividend (sampled only in the start cycle)
//   src_b       in   WIDTH    divisor  (sampled only in the start cycle)
//   hold        in   1        E stage held by other stall sources
//   cancel      in   1        E-stage flush; aborts any operation
//   div_stall   out  1        pipeline stall request (combinational)
//   div_ready   out  1        div_result valid for the instruction in E
//   div_result  out  2*WIDTH  {remainder, quotient}
//   dbg_state   out  2        current FSM state (IDLE=0, DIV=1, DONE=2)
//
// Handshake: div_en is a level "request" held by the pipeline while the
// instruction sits in E. The divider accepts it in IDLE (div_stall=1 that
// cycle), keeps div_stall high through all iterations, then drops div_stall
// and raises div_ready in DONE. The instruction leaves E on the first DONE
// cycle with hold=0; div_en seen in DONE is never treated as a new request.
// -----------------------------------------------------------------------------
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_en,
    input  logic                 div_signed,
    input  logic [WIDTH-1:0]     src_a,
    input  logic [WIDTH-1:0]     src_b,
    input  logic                 hold,
    input  logic                 cancel,
    output logic                 div_stall,
    output logic                 div_ready,
    output logic [2*WIDTH-1:0]   div_result,
    output logic [1:0]           dbg_state
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;       // partial remainder
    logic [WIDTH-1:0] quot;      // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH:0]   b_mag;     // divisor magnitude
    logic [WIDTH-1:0] a_raw;     // original dividend, needed for the divide-by-zero result
    logic             sign_q;
    logic             sign_r;
    logic             b_zero;

    logic             start;
    logic             step;
    logic             finish;

    // Start-cycle operand conditioning. The dividend magnitude fits in WIDTH
    // bits even for -2^(WIDTH-1) (0x80000000 read as unsigned); the divisor
    // magnitude is carried in WIDTH+1 bits for the trial compare.
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH:0]   b_mag_in;

    always_comb begin
        neg_a    = div_signed & src_a[WIDTH-1];
        neg_b    = div_signed & src_b[WIDTH-1];
        a_mag    = neg_a ? (~src_a + 1'b1) : src_a;
        b_mag_in = neg_b ? -{1'b1, src_b} : {1'b0, src_b};
    end

    // One restoring step: shift rem:quot left, trial-subtract the divisor.
    // When the subtraction succeeds the true difference is below |b| and so
    // fits in WIDTH bits, which is why the modulo-2^WIDTH difference suffices.
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quot_nxt;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [2*WIDTH-1:0] res_fin;

    always_comb begin
        rem_sh   = {rem, quot[WIDTH-1]};
        ge       = (rem_sh >= b_mag);
        diff     = rem_sh[WIDTH-1:0] - b_mag[WIDTH-1:0];
        rem_nxt  = ge ? diff : rem_sh[WIDTH-1:0];
        quot_nxt = {quot[WIDTH-2:0], ge};
        q_fix    = sign_q ? -quot_nxt : quot_nxt;
        r_fix    = sign_r ? -rem_nxt  : rem_nxt;
        res_fin  = b_zero ? {a_raw, {WIDTH{1'b1}}} : {r_fix, q_fix};
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        div_stall = 1'b0;
        div_ready = 1'b0;
        start     = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (div_en && !cancel) begin
                    start     = 1'b1;
                    div_stall = 1'b1;
                    state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                step      = !cancel;
                div_stall = !cancel;
                if (cnt == LAST_CNT) begin
                    finish    = !cancel;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                div_ready = !cancel;
                if (!hold) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (cancel) begin
            state_nxt = S_IDLE;
        end
        // The stall/ready outputs are combinational, so force them low while
        // reset is asserted rather than waiting for the registered state.
        if (!rst) begin
            div_stall = 1'b0;
            div_ready = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            rem        <= '0;
            quot       <= '0;
            b_mag      <= '0;
            a_raw      <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            b_zero     <= 1'b0;
            div_result <= '0;
        end else if (start) begin
            cnt    <= '0;
            rem    <= '0;
            quot   <= a_mag;
            b_mag  <= b_mag_in;
            a_raw  <= src_a;
            sign_q <= neg_a ^ neg_b;
            sign_r <= neg_a;
            b_zero <= (src_b == '0);
        end else if (step) begin
            cnt  <= cnt + CW'(1);
            rem  <= rem_nxt;
            quot <= quot_nxt;
            if (finish) begin
                div_result <= res_fin;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_iter_divider.sv
// -----------------------------------------------------------------------------
// tb_iter_divider
//   Self-checking bench for iter_divider. Expected results come from plain
//   integer division on 64-bit values; latency and handshake expectations
//   come from the cycle counts of the divider's external behaviour.
// -----------------------------------------------------------------------------
module tb_iter_divider;

    localparam int W = 32;
    localparam int STALL_CYCLES = W + 1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           div_en = 1'b0;
    logic           div_signed = 1'b0;
    logic [W-1:0]   src_a = '0;
    logic [W-1:0]   src_b = '0;
    logic           hold = 1'b0;
    logic           cancel = 1'b0;
    logic           div_stall;
    logic           div_ready;
    logic [2*W-1:0] div_result;
    logic [1:0]     dbg_state;

    int total = 0;
    int bad   = 0;
    logic [2*W-1:0] last_res = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    iter_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .div_en     (div_en),
        .div_signed (div_signed),
        .src_a      (src_a),
        .src_b      (src_b),
        .hold       (hold),
        .cancel     (cancel),
        .div_stall  (div_stall),
        .div_ready  (div_ready),
        .div_result (div_result),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: MIPS DIV/DIVU semantics from ordinary integer division.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Runs one divide: counts stall cycles, checks the result, optionally
    // holds DONE for hold_n cycles with div_en still asserted, then retires.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input int hold_n);
        logic [63:0] exp;
        int stalls;
        bit got;
        exp = ref_div(a, b, sgn);
        @(posedge clk); #1;
        div_en = 1'b1; src_a = a; src_b = b; div_signed = sgn; hold = 1'b0;
        stalls = 0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                // Operands must be ignored after the start cycle; hold must be
                // ignored during iteration.
                src_a = $urandom;
                src_b = $urandom;
                hold  = (k < STALL_CYCLES) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
            if (div_stall) stalls++;
            if (div_ready) got = 1'b1;
        end
        hold = 1'b0;
        check_eq("ready_seen", 64'(got), 64'd1);
        check_eq("stall_cycles", 64'(stalls), 64'(STALL_CYCLES));
        check_eq("result", div_result, exp);
        if (hold_n > 0) begin
            hold = 1'b1;
            for (int i = 1; i <= hold_n; i++) begin
                @(posedge clk); #1;
                if (i == hold_n) hold = 1'b0;
                @(negedge clk);
                check_eq("hold_ready", 64'(div_ready), 64'd1);
                check_eq("hold_stall", 64'(div_stall), 64'd0);
                check_eq("hold_result", div_result, exp);
                check_eq("hold_state", 64'(dbg_state), 64'(DONE_ENC));
            end
        end
        @(posedge clk); #1;
        div_en = 1'b0;
        @(negedge clk);
        check_eq("retire_ready", 64'(div_ready), 64'd0);
        check_eq("retire_stall", 64'(div_stall), 64'd0);
        check_eq("retire_result", div_result, exp);
        last_res = exp;
    endtask

    task automatic cancel_mid();
        @(posedge clk); #1;
        div_en = 1'b1; div_signed = 1'b0;
        src_a = $urandom; src_b = 32'($urandom_range(1, 1000));
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
        end
        cancel = 1'b1;
        @(negedge clk);
        check_eq("cancel_stall", 64'(div_stall), 64'd0);
        check_eq("cancel_ready", 64'(div_ready), 64'd0);
        @(posedge clk); #1;
        cancel = 1'b0;
        div_en = 1'b0;
        @(negedge clk);
        check_eq("post_cancel_stall", 64'(div_stall), 64'd0);
        check_eq("post_cancel_ready", 64'(div_ready), 64'd0);
        check_eq("post_cancel_result", div_result, last_res);
    endtask

    task automatic cancel_idle();
        @(posedge clk); #1;
        div_en = 1'b1; cancel = 1'b1; src_a = 32'd50; src_b = 32'd5; div_signed = 1'b0;
        @(negedge clk);
        check_eq("cancel_en_stall", 64'(div_stall), 64'd0);
        @(posedge clk); #1;
        div_en = 1'b0; cancel = 1'b0;
        @(negedge clk);
        check_eq("no_start_stall", 64'(div_stall), 64'd0);
        check_eq("no_start_ready", 64'(div_ready), 64'd0);
    endtask

    task automatic reset_mid();
        @(posedge clk); #1;
        div_en = 1'b1; div_signed = 1'b1; src_a = 32'd12345; src_b = 32'd17;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("rst_mid_stall", 64'(div_stall), 64'd0);
        check_eq("rst_mid_ready", 64'(div_ready), 64'd0);
        check_eq("rst_mid_result", div_result, 64'd0);
        div_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_res = '0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_stall", 64'(div_stall), 64'd0);
        check_eq("reset_ready", 64'(div_ready), 64'd0);
        check_eq("reset_result", div_result, 64'd0);
        rst = 1'b1;

        run_div(32'd100, 32'd7, 1'b0, 0);
        run_div(-32'sd7, 32'd2, 1'b1, 0);
        run_div(32'd7, -32'sd2, 1'b1, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_div(32'd5, 32'd0, 1'b0, 0);
        run_div(-32'sd5, 32'd0, 1'b1, 2);
        run_div(32'd1000, 32'd3, 1'b1, 5);

        cancel_mid();
        run_div(32'd9, 32'd3, 1'b0, 0);
        cancel_idle();

        reset_mid();
        run_div(32'd12345, 32'd17, 1'b1, 0);

        for (int n = 0; n < 40; n++) begin
            run_div(pick(), pick(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
